// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, synchronous-read 32-bit memory
// between the UART programmer, the data port and the fetch port.
// Ports:
//   clk, Rst (async, active-low)
//   prog_mode/prog_req/prog_addr/prog_din -> prog_ack   programmer write port
//   d_req/d_we/d_be/d_addr/d_din -> d_dout/d_valid      data port
//   i_req/i_addr -> i_dout/i_valid                      fetch port
//   mem_hold                                            core stall (combinational)
//   m_en/m_we/m_addr/m_din <- m_dout                    memory side
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              prog_mode,
  input  logic              prog_req,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_din,
  output logic              prog_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_din,
  output logic [31:0]       d_dout,
  output logic              d_valid,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_dout,
  output logic              i_valid,
  output logic              mem_hold,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_din,
  input  logic [31:0]       m_dout
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_PROG} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_DATA, OWN_FETCH} owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e      state_q, state_d;
  owner_e      rd_owner_q, rd_owner_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        d_valid_q, d_valid_d;
  logic        i_valid_q, i_valid_d;
  logic        prog_ack_q, prog_ack_d;
  logic [31:0] d_hold_q, d_hold_d;
  logic [31:0] i_hold_q, i_hold_d;

  logic        data_grant;
  logic        fetch_grant;
  logic        prog_grant;

  // Grant selection; gated by Rst so the memory port idles while in reset.
  always_comb begin
    data_grant  = 1'b0;
    fetch_grant = 1'b0;
    prog_grant  = 1'b0;
    if (Rst) begin
      case (state_q)
        ST_RUN: begin
          if (i_req && (starve_cnt_q == STARVE_LIM)) fetch_grant = 1'b1;
          else if (d_req)                            data_grant  = 1'b1;
          else if (i_req)                            fetch_grant = 1'b1;
        end
        ST_PROG: prog_grant = prog_req;
        default: ;
      endcase
    end
  end

  // Memory request mux.
  always_comb begin
    m_en   = data_grant | fetch_grant | prog_grant;
    m_we   = 4'h0;
    m_addr = '0;
    m_din  = 32'h0;
    if (data_grant) begin
      m_addr = d_addr;
      if (d_we) begin
        m_we  = d_be;
        m_din = d_din;
      end
    end else if (fetch_grant) begin
      m_addr = i_addr;
    end else if (prog_grant) begin
      m_we   = 4'hF;
      m_addr = prog_addr;
      m_din  = prog_din;
    end
  end

  assign mem_hold = Rst & ((d_req & ~data_grant) | (state_q != ST_RUN));

  // Read data is routed straight from the memory in the response cycle;
  // the port not targeted keeps its last value.
  assign d_dout  = (rd_owner_q == OWN_DATA)  ? m_dout : d_hold_q;
  assign i_dout  = (rd_owner_q == OWN_FETCH) ? m_dout : i_hold_q;
  assign d_valid  = d_valid_q;
  assign i_valid  = i_valid_q;
  assign prog_ack = prog_ack_q;

  // Next-state and bookkeeping.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    rd_owner_d   = OWN_NONE;
    d_valid_d    = data_grant;
    i_valid_d    = fetch_grant;
    prog_ack_d   = prog_grant;
    d_hold_d     = d_dout;
    i_hold_d     = i_dout;

    case (state_q)
      ST_RUN:   if (prog_mode) state_d = ST_DRAIN;
      // No grants are made in DRAIN, so any read issued before it has
      // returned by the end of this cycle.
      ST_DRAIN: state_d = ST_PROG;
      ST_PROG:  if (!prog_mode && !prog_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    if (!i_req || fetch_grant)          starve_cnt_d = 4'h0;
    else if (starve_cnt_q < STARVE_LIM) starve_cnt_d = starve_cnt_q + 4'h1;

    if (data_grant && !d_we) rd_owner_d = OWN_DATA;
    else if (fetch_grant)    rd_owner_d = OWN_FETCH;
  end

  // State registers.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= ST_RUN;
      rd_owner_q   <= OWN_NONE;
      starve_cnt_q <= 4'h0;
      d_valid_q    <= 1'b0;
      i_valid_q    <= 1'b0;
      prog_ack_q   <= 1'b0;
      d_hold_q     <= 32'h0;
      i_hold_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      rd_owner_q   <= rd_owner_d;
      starve_cnt_q <= starve_cnt_d;
      d_valid_q    <= d_valid_d;
      i_valid_q    <= i_valid_d;
      prog_ack_q   <= prog_ack_d;
      d_hold_q     <= d_hold_d;
      i_hold_q     <= i_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural synchronous-read memory, expected
// responses queued per port with their due cycle and compared on each negedge.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk;
  logic              rst;
  logic              prog_mode, prog_req;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_din;
  logic              prog_ack;
  logic              d_req, d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_din, d_dout;
  logic              d_valid;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_dout;
  logic              i_valid;
  logic              mem_hold;
  logic              m_en;
  logic [3:0]        m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_din, m_dout;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .Rst(rst),
    .prog_mode(prog_mode), .prog_req(prog_req), .prog_addr(prog_addr),
    .prog_din(prog_din), .prog_ack(prog_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_din(d_din),
    .d_dout(d_dout), .d_valid(d_valid),
    .i_req(i_req), .i_addr(i_addr), .i_dout(i_dout), .i_valid(i_valid),
    .mem_hold(mem_hold),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-indexed memory with byte enables and a registered read port.
  logic [31:0] mem [0:255];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
      mem[0]  <= 32'h11;
      mem[1]  <= 32'h22;
      mem[2]  <= 32'h33;
      mem[8]  <= 32'h1234_5678;
      mem[64] <= 32'h0000_00AB;
      m_dout  <= 32'h0;
    end else if (m_en) begin
      if (m_we == 4'h0) m_dout <= mem[m_addr[9:2]];
      else for (int b = 0; b < 4; b++)
        if (m_we[b]) mem[m_addr[9:2]][8*b +: 8] <= m_din[8*b +: 8];
    end
  end

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
  } sb_t;

  sb_t         d_sb[$];
  sb_t         i_sb[$];
  int unsigned a_sb[$];
  sb_t         d_e, i_e;
  int unsigned a_e;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Response monitor: a valid must appear exactly in the cycle it is due.
  always @(negedge clk) begin
    if (d_sb.size() != 0 && d_sb[0].cyc == cyc_cnt) begin
      d_e = d_sb.pop_front();
      check_eq("d_valid", 32'(d_valid), 32'h1);
      check_eq("d_dout", d_dout, d_e.data);
    end else check_eq("d_valid_idle", 32'(d_valid), 32'h0);
    if (i_sb.size() != 0 && i_sb[0].cyc == cyc_cnt) begin
      i_e = i_sb.pop_front();
      check_eq("i_valid", 32'(i_valid), 32'h1);
      check_eq("i_dout", i_dout, i_e.data);
    end else check_eq("i_valid_idle", 32'(i_valid), 32'h0);
    if (a_sb.size() != 0 && a_sb[0] == cyc_cnt) begin
      a_e = a_sb.pop_front();
      check_eq("prog_ack", 32'(prog_ack), 32'h1);
    end else check_eq("prog_ack_idle", 32'(prog_ack), 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_din = 32'h0;
    i_req = 1'b0; i_addr = '0;
    prog_req = 1'b0; prog_addr = '0; prog_din = 32'h0;
  endtask

  task automatic push_d(input logic [31:0] data);
    d_sb.push_back('{cyc: cyc_cnt + 1, data: data});
  endtask

  task automatic push_i(input logic [31:0] data);
    i_sb.push_back('{cyc: cyc_cnt + 1, data: data});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_d_valid"},  32'(d_valid),  32'h0);
    check_eq({tag, "_i_valid"},  32'(i_valid),  32'h0);
    check_eq({tag, "_prog_ack"}, 32'(prog_ack), 32'h0);
    check_eq({tag, "_d_dout"},   d_dout,        32'h0);
    check_eq({tag, "_i_dout"},   i_dout,        32'h0);
    check_eq({tag, "_m_en"},     32'(m_en),     32'h0);
    check_eq({tag, "_m_we"},     32'(m_we),     32'h0);
    check_eq({tag, "_m_addr"},   m_addr,        32'h0);
    check_eq({tag, "_m_din"},    m_din,         32'h0);
    check_eq({tag, "_mem_hold"}, 32'(mem_hold), 32'h0);
  endtask

  logic [31:0] fv [3] = '{32'h11, 32'h22, 32'h33};
  logic [31:0] pv [3] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; preload = 1'b1; prog_mode = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    preload = 1'b0;
    rst = 1'b1;
    tick();

    // Fetch-only stream, one access per cycle.
    for (int k = 0; k < 3; k++) begin
      i_req = 1'b1; i_addr = 32'(4 * k);
      push_i(fv[k]);
      #1;
      check_eq("fetch_hold", 32'(mem_hold), 32'h0);
      check_eq("fetch_m_en", 32'(m_en), 32'h1);
      tick();
    end
    idle(); tick();

    // Data and fetch contend: data first, fetch next cycle.
    d_req = 1'b1; d_addr = 32'h100; i_req = 1'b1; i_addr = 32'h0;
    push_d(32'hAB);
    #1;
    check_eq("cont_hold", 32'(mem_hold), 32'h0);
    check_eq("cont_m_addr", m_addr, 32'h100);
    tick();
    d_req = 1'b0;
    push_i(32'h11);
    #1;
    check_eq("cont_fetch_addr", m_addr, 32'h0);
    tick();
    idle(); tick();

    // Starvation: fetch wins in the 5th consecutive contended cycle.
    for (int k = 0; k < 6; k++) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; i_req = 1'b1; i_addr = 32'h4;
      if (k == 4) push_i(32'h22);
      else        push_d(32'hAB);
      #1;
      check_eq("starve_hold", 32'(mem_hold), (k == 4) ? 32'h1 : 32'h0);
      check_eq("starve_m_addr", m_addr, (k == 4) ? 32'h4 : 32'h100);
      tick();
    end
    idle(); tick();

    // Store and fetch to the same word: store first, fetch sees merged data.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h20; d_din = 32'hDEAD_BEEF;
    i_req = 1'b1; i_addr = 32'h20;
    push_d(32'hAB);
    #1;
    check_eq("st_m_we", 32'(m_we), 32'h3);
    check_eq("st_m_din", m_din, 32'hDEAD_BEEF);
    tick();
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    push_i(32'h1234_BEEF);
    tick();
    // Store with no byte enables: granted, nothing written.
    i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h0; d_addr = 32'h20; d_din = 32'hFFFF_FFFF;
    push_d(32'hAB);
    #1;
    check_eq("be0_m_en", 32'(m_en), 32'h1);
    check_eq("be0_m_we", 32'(m_we), 32'h0);
    tick();
    d_req = 1'b0; d_we = 1'b0;
    i_req = 1'b1; i_addr = 32'h20;
    push_i(32'h1234_BEEF);
    tick();
    idle(); tick();

    // Programming mode entry with a load in flight.
    d_req = 1'b1; d_addr = 32'h100; prog_mode = 1'b1;
    push_d(32'hAB);
    #1;
    check_eq("pm_entry_hold", 32'(mem_hold), 32'h0);
    tick();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0;
    prog_req = 1'b1; prog_addr = 32'h0; prog_din = 32'h5555_5555;
    #1;
    check_eq("drain_hold", 32'(mem_hold), 32'h1);
    check_eq("drain_m_en", 32'(m_en), 32'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      prog_req = 1'b1; prog_addr = 32'(4 * k); prog_din = pv[k];
      a_sb.push_back(cyc_cnt + 1);
      #1;
      check_eq("prog_m_we", 32'(m_we), 32'hF);
      check_eq("prog_m_addr", m_addr, 32'(4 * k));
      check_eq("prog_m_din", m_din, pv[k]);
      check_eq("prog_hold", 32'(mem_hold), 32'h1);
      tick();
    end
    prog_req = 1'b0; prog_mode = 1'b0;
    #1;
    check_eq("prog_exit_hold", 32'(mem_hold), 32'h1);
    check_eq("prog_exit_m_en", 32'(m_en), 32'h0);
    tick();
    push_i(pv[0]);
    #1;
    check_eq("run_again_hold", 32'(mem_hold), 32'h0);
    check_eq("run_again_m_en", 32'(m_en), 32'h1);
    tick();
    i_addr = 32'h8;
    push_i(pv[2]);
    tick();
    idle(); tick();

    // Async reset while a fetch read is in flight: response dropped.
    i_req = 1'b1; i_addr = 32'h4;
    #1;
    check_eq("rr_issue_m_en", 32'(m_en), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("rr");
    tick();
    check_eq("rr_i_valid", 32'(i_valid), 32'h0);
    check_eq("rr_i_dout", i_dout, 32'h0);
    rst = 1'b1;
    idle();
    tick();
    i_req = 1'b1; i_addr = 32'h8;
    push_i(pv[2]);
    tick();
    d_req = 1'b1; d_addr = 32'h100; i_addr = 32'h0;
    push_d(32'hAB);
    #1;
    check_eq("rr_cont_hold", 32'(mem_hold), 32'h0);
    tick();
    d_req = 1'b0;
    push_i(pv[0]);
    tick();
    idle();
    tick(); tick();

    check_eq("d_sb_left", 32'(d_sb.size()), 32'h0);
    check_eq("i_sb_left", 32'(i_sb.size()), 32'h0);
    check_eq("a_sb_left", 32'(a_sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, synchronous-read 32-bit memory among three requesters: the UART programmer, the Memory-stage data port and the Fetch-stage instruction port. It sits between the core's `mem_*` / `imem_*` signals and the memory. It generates the core's `mem_hold` stall whenever a data access cannot be granted. A programming-mode FSM gives the UART programmer exclusive ownership of the memory.

## Interface
- `ADDR_W`, 32, address width (byte address; the memory is word-indexed by `addr[ADDR_W-1:2]` internally)
- `STARVE_MAX`, 4, consecutive lost cycles after which fetch wins over data (range 1..15)
- `clk`  in  1  system clock; all state updates on rising edge
- `Rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `prog_mode`  in  1  UART programmer requests exclusive ownership
- `prog_req`  in  1  programmer write strobe (valid only in PROG)
- `prog_addr`  in  ADDR_W  programmer write address
- `prog_din`  in  32  programmer write data (full-word write)
- `prog_ack`  out  1  one-cycle pulse, cycle after programmer write accepted
- `d_req`  in  1  data access request
- `d_we`  in  1  1 = store, 0 = load
- `d_be`  in  4  store byte enables
- `d_addr`  in  ADDR_W  data address
- `d_din`  in  32  store data
- `d_dout`  out  32  load data
- `d_valid`  out  1  one-cycle pulse, cycle after data grant (loads and stores)
- `i_req`  in  1  fetch request
- `i_addr`  in  ADDR_W  fetch address
- `i_dout`  out  32  fetched instruction
- `i_valid`  out  1  one-cycle pulse, cycle after fetch grant
- `mem_hold`  out  1  pipeline stall to core (combinational)
- `m_en`  out  1  memory enable
- `m_we`  out  4  memory byte write enables
- `m_addr`  out  ADDR_W  memory address
- `m_din`  out  32  memory write data
- `m_dout`  in  32  memory read data; valid one cycle after `m_en` with `m_we` = 0

## Operation
- FSM states:
  - RUN: normal arbitration.
  - DRAIN: `prog_mode` was seen; no new grants; waits for the outstanding read response.
  - PROG: only the programmer is granted.
- Transitions:
  - RUN→DRAIN when `prog_mode` = 1.
  - DRAIN→PROG when no read is outstanding. DRAIN lasts at most 1 cycle.
  - PROG→RUN when `prog_mode` = 0 and `prog_req` = 0.
- RUN grant, one per cycle, combinational:
  - Data beats fetch.
  - Exception: when `starve_cnt` = `STARVE_MAX`, fetch beats data.
- `starve_cnt` (4 bits) increments each cycle `i_req` is asserted and not granted. It clears on fetch grant or when `i_req` = 0. It saturates at `STARVE_MAX`.
- Granted read: `m_en` = 1, `m_we` = 0. Store: `m_we` = `d_be`, `m_din` = `d_din`. Programmer: `m_we` = 4'hF.
- A store with `d_be` = 0 is still granted. `m_en` = 1, no bytes written, and `d_valid` pulses.
- Owner register `rd_owner` (NONE/DATA/FETCH) records the read issued this cycle.
- Next cycle:
  - `m_dout` is routed to `d_dout` or `i_dout` by `rd_owner`.
  - The matching valid pulses.
  - The `*_dout` not targeted holds its previous value.
- `mem_hold` = (`d_req` & ~data_grant) | (state ≠ RUN).
- Fetch not granted: `i_valid` stays 0. The fetch stage retries with the same `i_addr`. No hold is raised for fetch.
- Same-cycle store and fetch to the same word: the store is granted; the fetch is served later and returns post-store data.
- In PROG, `d_req`/`i_req` are ignored (held off by `mem_hold`).

## Timing
- Reset (async, `Rst` = 0), all outputs:
  - state = RUN, `starve_cnt` = 0, `rd_owner` = NONE.
  - `d_valid` = `i_valid` = `prog_ack` = 0; `d_dout` = `i_dout` = 0.
  - `m_en` = 0, `m_we` = 0, `m_addr` = 0, `m_din` = 0.
  - `mem_hold` = 0 (combinational from inputs once state = RUN).
- Reset mid-read: the response is discarded and no valid pulse follows.
- Latency: grant in cycle N; `*_valid` and data in N+1. Back-to-back grants are allowed every cycle: 1 access/cycle throughput.
- `mem_hold` changes in the same cycle as `d_req`. The core holds `d_*` stable while `mem_hold` = 1.
- Entering PROG: a read granted in cycle N with `prog_mode` rising in N still returns in N+1 (DRAIN). PROG starts at N+2.
- `prog_ack` follows `prog_req` by 1 cycle. A `prog_req` in RUN or DRAIN is ignored (no ack).
- Leaving PROG: the first RUN grant is possible in the cycle after `prog_mode` falls.

## Test plan
- Fetch only: `i_req` = 1, `i_addr` = 0x0,0x4,0x8 on consecutive cycles, memory preloaded 0x11,0x22,0x33 → `i_valid` every cycle from cycle 1, `i_dout` = 0x11,0x22,0x33, `mem_hold` = 0.
- Contention: `d_req` load 0x100 (=0xAB) with `i_req` at 0x0 → data granted, `mem_hold` = 0, `d_dout` = 0xAB next cycle. Fetch granted the following cycle.
- Starvation: `STARVE_MAX` = 4, `d_req` and `i_req` held 6 cycles → fetch granted in cycle 4, `mem_hold` = 1 only in cycle 4, `starve_cnt` back to 0.
- Store/fetch hazard: store 0xDEADBEEF, `d_be` = 4'b0011 to 0x20 (old 0x12345678) with fetch at 0x20 → `i_dout` = 0x1234BEEF one cycle after the fetch grant.
- Programming: load outstanding, raise `prog_mode` → load `d_valid` pulses, DRAIN 1 cycle, `mem_hold` = 1. Then 3 `prog_req` writes → 3 `prog_ack` pulses, `m_we` = 4'hF. Drop `prog_mode` → fetch of the written word returns the new data.
- Async reset during an outstanding fetch read → `i_valid` stays 0, all outputs at reset values immediately, normal arbitration after `Rst` returns to 1.
